bcd_to_onehot_decoder: RTL
==========================

BCD_TO_ONEHOT_DECODER -- requirements
Module: bcd_to_onehot_decoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8: width of the saturating invalid-code counter.
REQ-002 SHALL have parameter HALT_ON_ERR, default 1: 1 means enter HALT on an invalid code, 0 means flag the code and continue.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: in_bcd holds a digit.
REQ-006 SHALL have port in_ready, output, 1: block accepts the digit this cycle.
REQ-007 SHALL have port in_bcd, input, 4: BCD digit; 0-9 valid, 10-15 invalid.
REQ-008 SHALL have port out_valid, output, 1: out_onehot and out_err hold a result.
REQ-009 SHALL have port out_ready, input, 1: downstream consumes the result this cycle.
REQ-010 SHALL have port out_onehot, output, 10: bit n set for digit n; all zero for an invalid code.
REQ-011 SHALL have port out_err, output, 1: the current result came from an invalid code.
REQ-012 SHALL have port err_clr, input, 1: clears err_count and leaves HALT.
REQ-013 SHALL have port err_count, output, ERR_CNT_W: number of invalid codes accepted, saturating.
REQ-014 SHALL have port halted, output, 1: FSM is in HALT.

Function
REQ-015 SHALL transfer an input when in_valid and in_ready are both high on a rising edge, and an output when out_valid and out_ready are both high.
REQ-016 SHALL register results with 1-cycle latency: a digit accepted at edge N appears on out_onehot/out_err with out_valid=1 after edge N.
REQ-017 SHALL drive in_ready = (state==RUN) and (!out_valid or out_ready), so back-to-back transfers sustain full throughput.
REQ-018 SHALL hold out_onehot, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on the edge where out_ready=1 and no new input is accepted.
REQ-020 SHALL have a two-state FSM: RUN and HALT.
REQ-021 SHALL go from RUN to HALT when HALT_ON_ERR=1 and an invalid code is accepted; the invalid result is still presented on the output.
REQ-022 SHALL go from HALT to RUN on the edge where err_clr=1.
REQ-023 SHALL hold in_ready=0 in HALT while the pending output still drains normally.
REQ-024 SHALL never leave RUN when HALT_ON_ERR=0.
REQ-025 SHALL increment err_count on each accepted invalid code and saturate at 2^ERR_CNT_W-1 (no wrap).
REQ-026 SHALL give err_clr priority over a simultaneous increment: the count becomes 0 and that invalid code is not counted.
REQ-027 SHALL keep halted equal to (state==HALT) with no added latency.

Reset
REQ-028 SHALL make the following true while rst=1, independent of clk: state=RUN, out_valid=0, out_onehot=0, out_err=0, err_count=0, halted=0.
REQ-029 SHALL discard any pending result and lose any in-flight handshake when rst is asserted mid-operation.
REQ-030 SHALL accept no input on the first edge after rst deasserts if in_ready is evaluated low at that edge; in_ready SHALL be 1 from the first cycle out of reset.

Structure
REQ-031 SHALL take BCD_W=4, OH_W=10 and the FSM state encoding (RUN, HALT) from shared package dec_pkg.
REQ-032 SHALL place the combinational BCD-to-one-hot mapping, including the invalid-code flag, in sub-module bcd_onehot_lut.
REQ-033 SHALL contain only the handshake, FSM and counter logic in the top level, with no latches.

Verification
REQ-034 SHALL cover a sweep: digits 0..9 streamed with out_ready=1 -> out_onehot goes 0000000001 through 1000000000, one result per cycle, out_err=0.
REQ-035 SHALL cover backpressure: digit 7, then out_ready=0 for 3 cycles -> out_onehot holds 0010000000, in_ready=0, and digit 3 is not accepted until out_ready rises.
REQ-036 SHALL cover halt: HALT_ON_ERR=1, digit 12 -> out_onehot=0, out_err=1, err_count=1, halted=1, in_ready=0; then err_clr pulse -> halted=0, err_count=0.
REQ-037 SHALL cover no-halt: HALT_ON_ERR=0, digits 15, 4 -> results {0, err=1} then {0000010000, err=0}, err_count=1, halted=0.
REQ-038 SHALL cover saturation: ERR_CNT_W=2, five invalid codes with err_clr held low -> err_count stays 3.
REQ-039 SHALL cover reset mid-stream: rst asserted while out_valid=1 -> out_valid, out_onehot and err_count become 0 immediately, and state=RUN.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the BCD-to-one-hot decoder slice.
//   BCD_W   : width of a BCD digit
//   OH_W    : width of the one-hot result (one bit per decimal digit)
//   state_e : decoder control state (RUN accepts digits, HALT blocks input)
package dec_pkg;
  localparam int BCD_W = 4;
  localparam int OH_W  = 10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;
endpackage

// File: rtl/bcd_onehot_lut.sv
// Combinational BCD digit to one-hot mapping.
//   bcd     : input digit, 0-9 valid, 10-15 invalid
//   onehot  : bit n set for digit n, all zero for an invalid code
//   invalid : high when bcd is outside 0-9
module bcd_onehot_lut
  import dec_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [OH_W-1:0]  onehot,
  output logic             invalid
);

  always_comb begin
    onehot  = '0;
    invalid = 1'b0;
    case (bcd)
      4'd0:    onehot = 10'b0000000001;
      4'd1:    onehot = 10'b0000000010;
      4'd2:    onehot = 10'b0000000100;
      4'd3:    onehot = 10'b0000001000;
      4'd4:    onehot = 10'b0000010000;
      4'd5:    onehot = 10'b0000100000;
      4'd6:    onehot = 10'b0001000000;
      4'd7:    onehot = 10'b0010000000;
      4'd8:    onehot = 10'b0100000000;
      4'd9:    onehot = 10'b1000000000;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/bcd_to_onehot_decoder.sv
// BCD digit to one-hot decoder with valid/ready handshakes, a RUN/HALT
// control FSM and a saturating invalid-code counter.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake, in_bcd is the digit
//   out_valid/out_ready   : output handshake, out_onehot/out_err the result
//   err_clr               : clears err_count and returns HALT to RUN
//   err_count             : saturating count of accepted invalid codes
//   halted                : FSM is in HALT
module bcd_to_onehot_decoder
  import dec_pkg::*;
#(
  parameter int ERR_CNT_W   = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BCD_W-1:0]     in_bcd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OH_W-1:0]      out_onehot,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 halted
);

  // Count up by one but stick at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

  state_e                 state;
  logic                   vld_p1;
  logic [OH_W-1:0]        onehot_p1;
  logic                   err_p1;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic [OH_W-1:0]        onehot_p0;
  logic                   invalid_p0;
  logic                   accept;

  // Stage p0: combinational decode of the presented digit
  bcd_onehot_lut u_lut (
    .bcd     (in_bcd),
    .onehot  (onehot_p0),
    .invalid (invalid_p0)
  );

  // The output register may be refilled in the same cycle it is drained.
  assign in_ready = (state == RUN) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  // Stage p1: registered result, FSM and error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      vld_p1    <= 1'b0;
      onehot_p1 <= '0;
      err_p1    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (accept) begin
        vld_p1    <= 1'b1;
        onehot_p1 <= onehot_p0;
        err_p1    <= invalid_p0;
      end else if (out_ready) begin
        vld_p1    <= 1'b0;
      end

      // err_clr outranks a simultaneous invalid code for both state and count.
      if (err_clr) begin
        state     <= RUN;
        err_cnt_q <= '0;
      end else if (accept && invalid_p0) begin
        err_cnt_q <= sat_inc(err_cnt_q);
        if (HALT_ON_ERR) state <= HALT;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_onehot = onehot_p1;
  assign out_err    = err_p1;
  assign err_count  = err_cnt_q;
  assign halted     = (state == HALT);

endmodule
